// File: rtl/ru_fault_allocator.sv
// BISR fault allocator: scans a snapshot of the PE fault matrix one
// column per cycle and binds redundant units to faulty columns in order.
module ru_fault_allocator #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4,
  localparam int CW = $clog2(COLS),
  localparam int SW = (NUM_RU > 1) ? $clog2(NUM_RU) : 1,
  localparam int NW = $clog2(NUM_RU + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stw_complete,
  input  logic [ROWS*COLS-1:0] stw_fault_mat,
  output logic [NUM_RU-1:0]    ru_en,
  output logic [CW*NUM_RU-1:0] ru_col_mapping,
  output logic [COLS-1:0]      col_repaired,
  output logic [SW*COLS-1:0]   col_ru_sel,
  output logic [COLS-1:0]      col_faulty,
  output logic                 ru_overflow,
  output logic                 busy,
  output logic                 alloc_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [NW-1:0] RU_MAX   = NW'(NUM_RU);

  logic [1:0]                  state_q, state_d;
  logic                        stw_q;
  logic [ROWS*COLS-1:0]        snap_q, snap_d;
  logic [CW-1:0]               col_q, col_d;
  logic [NW-1:0]               nru_q, nru_d;
  logic [NUM_RU-1:0][CW-1:0]   map_q, map_d;
  logic [NUM_RU-1:0]           en_q, en_d;
  logic [COLS-1:0][SW-1:0]     sel_q, sel_d;
  logic [COLS-1:0]             rep_q, rep_d;
  logic [COLS-1:0]             flt_q, flt_d;
  logic                        ovf_q, ovf_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic                        start;
  logic [COLS-1:0]             col_or;
  logic                        cur_flt;
  logic [SW-1:0]               ru_idx;

  assign start   = stw_complete & ~stw_q;
  assign cur_flt = col_or[col_q];
  assign ru_idx  = nru_q[SW-1:0];

  // Per-column OR of the snapshot across all rows.
  always_comb begin
    col_or = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        col_or[c] = col_or[c] | snap_q[r*COLS+c];
      end
    end
  end

  // FSM next state and allocation bookkeeping.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    col_d   = col_q;
    nru_d   = nru_q;
    map_d   = map_q;
    en_d    = en_q;
    sel_d   = sel_q;
    rep_d   = rep_q;
    flt_d   = flt_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SCAN;
          snap_d  = stw_fault_mat;
          col_d   = '0;
          nru_d   = '0;
          map_d   = '0;
          en_d    = '0;
          sel_d   = '0;
          rep_d   = '0;
          flt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_SCAN: begin
        flt_d[col_q] = cur_flt;
        if (cur_flt) begin
          if (nru_q < RU_MAX) begin
            map_d[ru_idx] = col_q;
            en_d[ru_idx]  = 1'b1;
            sel_d[col_q]  = ru_idx;
            rep_d[col_q]  = 1'b1;
            nru_d         = nru_q + NW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        col_d = col_q + CW'(1);
        if (col_q == LAST_COL) begin
          state_d = S_DONE;
          col_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      stw_q   <= 1'b0;
      snap_q  <= '0;
      col_q   <= '0;
      nru_q   <= '0;
      map_q   <= '0;
      en_q    <= '0;
      sel_q   <= '0;
      rep_q   <= '0;
      flt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stw_q   <= stw_complete;
      snap_q  <= snap_d;
      col_q   <= col_d;
      nru_q   <= nru_d;
      map_q   <= map_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      rep_q   <= rep_d;
      flt_q   <= flt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ru_en          = en_q & {NUM_RU{done_q}};
  assign ru_col_mapping = map_q & {(CW*NUM_RU){done_q}};
  assign col_repaired   = rep_q & {COLS{done_q}};
  assign col_ru_sel     = sel_q & {(SW*COLS){done_q}};
  assign col_faulty     = flt_q;
  assign ru_overflow    = ovf_q;
  assign busy           = busy_q;
  assign alloc_done     = done_q;

endmodule

// File: tb/tb_ru_fault_allocator.sv
// Randomized bench for ru_fault_allocator: two instances (2 and 4 RUs)
// share stimulus and are checked against a column-list reference model.
module tb_ru_fault_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stw = 1'b0;
  logic [15:0] mat = '0;

  logic [1:0] a_en;
  logic [3:0] a_map, a_rep, a_sel, a_flt;
  logic       a_ovf, a_busy, a_done;

  logic [3:0] b_en, b_rep, b_flt;
  logic [7:0] b_map, b_sel;
  logic       b_ovf, b_busy, b_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ru_fault_allocator #(.ROWS(4), .COLS(4), .NUM_RU(2)) u_a (
    .clk(clk), .rst(rst),
    .stw_complete(stw), .stw_fault_mat(mat),
    .ru_en(a_en), .ru_col_mapping(a_map),
    .col_repaired(a_rep), .col_ru_sel(a_sel),
    .col_faulty(a_flt), .ru_overflow(a_ovf),
    .busy(a_busy), .alloc_done(a_done)
  );

  ru_fault_allocator #(.ROWS(4), .COLS(4), .NUM_RU(4)) u_b (
    .clk(clk), .rst(rst),
    .stw_complete(stw), .stw_fault_mat(mat),
    .ru_en(b_en), .ru_col_mapping(b_map),
    .col_repaired(b_rep), .col_ru_sel(b_sel),
    .col_faulty(b_flt), .ru_overflow(b_ovf),
    .busy(b_busy), .alloc_done(b_done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: list faulty columns ascending, hand out RUs first-come.
  task automatic model(input logic [15:0] m, input int nru,
                       input int sw,
                       output logic [63:0] en, output logic [63:0] map,
                       output logic [63:0] rep, output logic [63:0] sel,
                       output logic [63:0] flt, output logic [63:0] ovf);
    int k;
    k = 0;
    en = 0; map = 0; rep = 0; sel = 0; flt = 0; ovf = 0;
    for (int c = 0; c < 4; c++) begin
      bit f;
      f = 0;
      for (int r = 0; r < 4; r++) f |= m[r*4+c];
      if (f) begin
        flt[c] = 1'b1;
        if (k < nru) begin
          en[k] = 1'b1;
          map   = map | (64'(c) << (k*2));
          rep[c] = 1'b1;
          sel   = sel | (64'(k) << (c*sw));
          k++;
        end else begin
          ovf = 1;
        end
      end
    end
  endtask

  task automatic cmp_all(input string t, input logic [15:0] m);
    logic [63:0] en, map, rep, sel, flt, ovf;
    model(m, 2, 1, en, map, rep, sel, flt, ovf);
    chk({t, ".a_en"},  64'(a_en),  en);
    chk({t, ".a_map"}, 64'(a_map), map);
    chk({t, ".a_rep"}, 64'(a_rep), rep);
    chk({t, ".a_sel"}, 64'(a_sel), sel);
    chk({t, ".a_flt"}, 64'(a_flt), flt);
    chk({t, ".a_ovf"}, 64'(a_ovf), ovf);
    model(m, 4, 2, en, map, rep, sel, flt, ovf);
    chk({t, ".b_en"},  64'(b_en),  en);
    chk({t, ".b_map"}, 64'(b_map), map);
    chk({t, ".b_rep"}, 64'(b_rep), rep);
    chk({t, ".b_sel"}, 64'(b_sel), sel);
    chk({t, ".b_flt"}, 64'(b_flt), flt);
    chk({t, ".b_ovf"}, 64'(b_ovf), ovf);
    chk({t, ".state"}, {62'd0, b_busy, b_done}, 64'd1);
  endtask

  // One allocation run observed for 12 cycles after the start edge.
  task automatic run(input string t, input logic [15:0] m,
                     input logic [15:0] m2, input bit restart,
                     input bit hold);
    int lat, bsy, rises;
    bit prev, gate_ok;
    lat = 0; bsy = 0; rises = 0; prev = 0; gate_ok = 1;
    @(negedge clk);
    mat = m;
    stw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) stw = 1'b0;
      if (restart && k == 2) begin
        mat = m2;
        stw = 1'b1;
      end
      if (restart && k == 3) stw = 1'b0;
      if (a_busy) bsy++;
      if (a_done && !prev) begin
        rises++;
        if (lat == 0) lat = k;
      end
      if (!a_done && (a_en != 0 || a_rep != 0 || a_map != 0 ||
                      a_sel != 0 || b_en != 0 || b_map != 0))
        gate_ok = 0;
      if (a_busy != b_busy || a_done != b_done) gate_ok = 0;
      prev = a_done;
    end
    stw = 1'b0;
    chk({t, ".lat"},   64'(lat),   64'd5);
    chk({t, ".busy"},  64'(bsy),   64'd4);
    chk({t, ".rises"}, 64'(rises), 64'd1);
    chk({t, ".gate"},  64'(gate_ok), 64'd1);
    cmp_all(t, m);
  endtask

  initial begin
    logic [15:0] m;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.outs", {a_en, a_map, a_rep, a_sel, a_flt, a_ovf,
                     a_busy, a_done, b_en, b_map, b_sel}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run("zero", 16'h0000, 16'h0, 0, 0);
    chk("zero.ovf", 64'(a_ovf), 64'd0);

    run("col2", 16'h4040, 16'h0, 0, 0);
    chk("col2.en",  64'(a_en),  64'h1);
    chk("col2.rep", 64'(a_rep), 64'h4);

    run("c013", 16'h8021, 16'h0, 0, 0);
    chk("c013.en",  64'(a_en),  64'h3);
    chk("c013.map", 64'(a_map), 64'h4);
    chk("c013.ovf", 64'(a_ovf), 64'h1);
    chk("c013.flt", 64'(a_flt), 64'hB);

    run("restart", 16'h0008, 16'h0001, 1, 0);
    chk("restart.map", 64'(a_map), 64'h3);

    run("hold", 16'h0210, 16'h0, 0, 1);

    // Asynchronous abort two cycles into the scan.
    @(negedge clk);
    mat = 16'hFFFF;
    stw = 1'b1;
    @(negedge clk);
    stw = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.busy_pre", 64'(a_busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort.outs", {a_en, a_map, a_rep, a_sel, a_flt, a_ovf,
                       a_busy, a_done, b_en, b_map, b_sel,
                       b_flt, b_ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run("post_abort", 16'h1200, 16'h0, 0, 0);

    run("all", 16'hFFFF, 16'h0, 0, 0);
    chk("all.b_en",  64'(b_en),  64'hF);
    chk("all.b_map", 64'(b_map), 64'hE4);
    chk("all.b_sel", 64'(b_sel), 64'hE4);
    chk("all.b_ovf", 64'(b_ovf), 64'h0);
    run("clear", 16'h0000, 16'h0, 0, 0);
    chk("clear.b_en", 64'(b_en), 64'h0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: m = 16'($urandom);
        1: m = 16'($urandom & $urandom);
        2: m = 16'($urandom & $urandom & $urandom);
        default: m = 16'(1 << $urandom_range(0, 15));
      endcase
      run($sformatf("rnd%0d", i), m, 16'($urandom),
          bit'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
